// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder leaf cell: default counter width and
// a behavioural reference of the {cout,sum} function.
package full_adder_pkg;

  localparam int CNT_W_DEFAULT = 16;

  // Reference full-adder function returning {cout, sum}; X on an input propagates.
  function automatic logic [1:0] fa_eval(input logic a, input logic b, input logic cin);
    logic p_s;
    p_s = a ^ b;
    return {(a & b) | (cin & p_s), p_s ^ cin};
  endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// Half adder building block: s = x ^ y, c = x & y. Pure combinational.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders. The combinational sum/cout
// are the primary outputs; a registered copy of the result and a saturating
// count of carry-out events are kept as debug taps.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_cnt
);

  logic             ha0_s_s;
  logic             ha0_c_s;
  logic             ha1_c_s;
  logic [CNT_W-1:0] carry_cnt_q;
  logic [CNT_W-1:0] carry_cnt_d;

  // First stage adds the two addend bits.
  half_adder ha0 (
    .x (a),
    .y (b),
    .s (ha0_s_s),
    .c (ha0_c_s)
  );

  // Second stage folds in the carry input and produces the final sum.
  half_adder ha1 (
    .x (ha0_s_s),
    .y (cin),
    .s (sum),
    .c (ha1_c_s)
  );

  // A carry leaves the cell if either stage generated one; they are mutually exclusive.
  assign cout      = ha0_c_s | ha1_c_s;
  assign carry_cnt = carry_cnt_q;

  // Next count: bump on a carry-out, but hold once all-ones so the tap never wraps.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (cout && (carry_cnt_q != {CNT_W{1'b1}})) begin
      carry_cnt_d = carry_cnt_q + CNT_W'(1);
    end else begin
      carry_cnt_d = carry_cnt_q;
    end
  end

  // Observability registers: capture the result each edge, cleared at once by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= 1'b0;
      cout_q      <= 1'b0;
      carry_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sum_q       <= sum;
      cout_q      <= cout;
      carry_cnt_q <= carry_cnt_d;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: truth-table sweep, random combinational checks,
// registered-path latency, counter saturation and asynchronous reset.
module tb_full_adder;
  import full_adder_pkg::*;

  typedef struct {
    logic [2:0] abc;
    logic       exp_cout;
    logic       exp_sum;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        a, b, cin;
  logic        sum, cout, sum_q, cout_q;
  logic [15:0] carry_cnt;
  logic        sum2, cout2, sum_q2, cout_q2;
  logic [1:0]  carry_cnt2;

  int n_cmp;
  int n_bad;

  full_adder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q), .carry_cnt(carry_cnt)
  );

  full_adder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum2), .cout(cout2), .sum_q(sum_q2), .cout_q(cout_q2), .carry_cnt(carry_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [2:0] v);
    {a, b, cin} = v;
  endtask

  initial begin
    vec_t       vecs[8];
    logic [2:0] r;
    logic [1:0] ref_v;
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{3'b000, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 1'b0, 1'b1};
    vecs[2] = '{3'b010, 1'b0, 1'b1};
    vecs[3] = '{3'b011, 1'b1, 1'b0};
    vecs[4] = '{3'b100, 1'b0, 1'b1};
    vecs[5] = '{3'b101, 1'b1, 1'b0};
    vecs[6] = '{3'b110, 1'b1, 1'b0};
    vecs[7] = '{3'b111, 1'b1, 1'b1};

    rst_n = 1'b0;
    apply(3'b000);
    #2;
    check("reset_sum_q", {31'b0, sum_q}, 32'd0);
    check("reset_cout_q", {31'b0, cout_q}, 32'd0);
    check("reset_cnt", {16'b0, carry_cnt}, 32'd0);

    // Combinational sweep while reset is held: reset must not affect sum/cout.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].abc);
      #1;
      check("tt_sum", {31'b0, sum}, {31'b0, vecs[i].exp_sum});
      check("tt_cout", {31'b0, cout}, {31'b0, vecs[i].exp_cout});
    end

    // Random vectors against the package reference.
    for (int i = 0; i < 12; i++) begin
      r = 3'($urandom_range(0, 7));
      apply(r);
      #1;
      ref_v = fa_eval(r[2], r[1], r[0]);
      check("rnd_cout_sum", {30'b0, cout, sum}, {30'b0, ref_v});
    end

    // X on an input reaches sum.
    a = 1'bx; b = 1'b0; cin = 1'b0;
    #1;
    check("x_sum", {31'b0, sum}, {31'b0, 1'bx});
    check("still_reset_cnt", {16'b0, carry_cnt}, 32'd0);

    // Registered path: 011 captured on the first edge after reset release.
    @(negedge clk);
    apply(3'b011);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reg_sum_q", {31'b0, sum_q}, 32'd0);
    check("reg_cout_q", {31'b0, cout_q}, 32'd1);
    check("reg_cnt", {16'b0, carry_cnt}, 32'd1);
    #2;
    apply(3'b000);
    #1;
    check("mid_sum", {31'b0, sum}, 32'd0);
    check("mid_cout", {31'b0, cout}, 32'd0);
    check("mid_cout_q_hold", {31'b0, cout_q}, 32'd1);
    @(posedge clk); #1;
    check("next_cout_q", {31'b0, cout_q}, 32'd0);
    check("next_cnt", {16'b0, carry_cnt}, 32'd1);

    // Clear the count between edges before the counter run.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("pulse_cnt", {16'b0, carry_cnt}, 32'd0);
    rst_n = 1'b1;

    // 111 for 5 edges, with the 2-bit instance saturating at 3.
    @(negedge clk);
    apply(3'b111);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("cnt_run", {16'b0, carry_cnt}, k);
      check("cnt2_sat", {30'b0, carry_cnt2}, (k > 3) ? 32'd3 : k);
    end
    @(negedge clk);
    apply(3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_hold", {16'b0, carry_cnt}, 32'd5);
    check("cnt2_hold", {30'b0, carry_cnt2}, 32'd3);
    check("idle_sum_q", {30'b0, cout_q, sum_q}, 32'd0);
    @(negedge clk);
    apply(3'b111);
    repeat (6) @(posedge clk);
    #1;
    check("cnt2_sat6", {30'b0, carry_cnt2}, 32'd3);
    check("cnt_11", {16'b0, carry_cnt}, 32'd11);
    check("reg_111", {30'b0, cout_q, sum_q}, 32'd3);

    // Asynchronous reset mid-cycle; combinational path keeps tracking inputs.
    @(negedge clk);
    #2;
    apply(3'b101);
    rst_n = 1'b0;
    #1;
    check("arst_cnt", {16'b0, carry_cnt}, 32'd0);
    check("arst_regs", {30'b0, cout_q, sum_q}, 32'd0);
    check("arst_comb", {30'b0, cout, sum}, 32'd2);
    apply(3'b010);
    #1;
    check("arst_comb2", {30'b0, cout, sum}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_regs", {30'b0, cout_q, sum_q}, 32'd1);
    check("rel_cnt", {16'b0, carry_cnt}, 32'd0);
    @(negedge clk);
    apply(3'b110);
    @(posedge clk); #1;
    check("restart_cnt", {16'b0, carry_cnt}, 32'd1);
    check("restart_regs", {30'b0, cout_q, sum_q}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
